// File: rtl/clk_div.sv
// clk_div: programmable 50%-duty clock divider.
// The output toggles every `division` clk cycles. A division of 0 behaves
// like 1. `division` may be changed at run time without a reset. The count
// is never cleared on a change, and the >= compare makes an oversized count
// toggle on the next edge.
// Optional feature macro: CLKDIV_TICK_EN adds a one-cycle `tick` pulse in
// the cycle after each `divided` transition.
module clk_div #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] division,
`ifdef CLKDIV_TICK_EN
  output logic             tick,
`endif
  output logic             divided
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] lim;
  logic             toggle;

  // Effective limit and toggle decision; division 0 clamps to a limit of 0.
  always_comb begin
    lim      = '0;
    toggle   = 1'b0;
    cnt_next = cnt_reg;
    if (division != '0) begin
      lim = division - 1'b1;
    end
    if (cnt_reg >= lim) begin
      toggle   = 1'b1;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Half-period counter and output flop; divided is driven straight from the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      divided <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (toggle) begin
        divided <= ~divided;
      end
    end
  end

`ifdef CLKDIV_TICK_EN
  // Tick flop: high for the one cycle following each toggle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= toggle;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div.sv
// tb_clk_div: directed test of clk_div with hand-computed expected waveforms.
// Outputs are sampled at the falling edge. Inputs are driven at the falling
// edge or between edges.
`timescale 1ns/1ps
module tb_clk_div;

  localparam int DIV_W = 25;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] division;
  logic             divided;
`ifdef CLKDIV_TICK_EN
  logic             tick;
`endif

  int n_checks;
  int n_fail;

  clk_div #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .division (division),
`ifdef CLKDIV_TICK_EN
    .tick     (tick),
`endif
    .divided  (divided)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports every check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", tag, got, $time);
    end
  endtask

  // Apply reset across two rising edges, then release at a falling edge.
  task automatic reset_with(input logic [DIV_W-1:0] d);
    rst      = 1'b1;
    division = d;
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", {31'b0, divided}, 0);
    rst = 1'b0;
  endtask

  int exp_v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    division = 1;

    // Reset held across several edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_held", {31'b0, divided}, 0);
`ifdef CLKDIV_TICK_EN
      check("rst_tick", {31'b0, tick}, 0);
`endif
    end

    // division = 1: 1,0,1,0.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("div1", {31'b0, divided}, (i % 2 == 0) ? 1 : 0);
    end

    // Retune 1 -> 2 in a cycle where divided = 1: 1,0,0,1,1.
    @(negedge clk);
    check("pre_retune", {31'b0, divided}, 1);
    division = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: exp_v = 1;
        1: exp_v = 0;
        2: exp_v = 0;
        3: exp_v = 1;
        default: exp_v = 1;
      endcase
      check("retune", {31'b0, divided}, exp_v);
    end

    // Asynchronous assertion between edges clears divided immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {31'b0, divided}, 0);

    // division = 0 behaves like 1.
    reset_with(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("div0", {31'b0, divided}, (i % 2 == 0) ? 1 : 0);
    end

    // division = 5 for 40 cycles: low after edges 1..4, high 5..9, low 10..14, ...
    reset_with(5);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("div5", {31'b0, divided}, (k / 5) % 2);
    end

    // Shrink 8 -> 3 with cnt = 6: toggle on the next edge, then 3-cycle halves.
    reset_with(8);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
    end
    check("shrink_pre", {31'b0, divided}, 0);
    division = 3;
    for (int k = 7; k <= 13; k++) begin
      @(negedge clk);
      case (k)
        7, 8, 9:   exp_v = 1;
        10, 11, 12: exp_v = 0;
        default:   exp_v = 1;
      endcase
      check("shrink", {31'b0, divided}, exp_v);
    end

`ifdef CLKDIV_TICK_EN
    // division = 3: tick after edges 3, 6, 9, ... ; divided toggles at the same edges.
    reset_with(3);
    check("tick_rst", {31'b0, tick}, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("tick3", {31'b0, tick}, (k % 3 == 0) ? 1 : 0);
      check("tick3_div", {31'b0, divided}, (k / 3) % 2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div.md
# clk_div

Programmable clock divider. It produces a 50%-duty square wave, `divided`, whose half-period is `division` cycles of `clk`. It sits in the CPU clocking path and derives slow strobes and clocks, such as a visible single-step clock, from the board clock. The divider may be retuned at run time without a reset.

## Interface
Parameters:
- `DIV_W`, default 25: width of `division` and of the internal counter.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `division`  in  `DIV_W`: half-period length in `clk` cycles; sampled every cycle.
- `divided`  out  1: divided clock output, driven directly from a flop (glitch-free).
- `tick`  out  1: present only with `CLKDIV_TICK_EN`; one-cycle pulse in the cycle after each `divided` toggle.

## Operation
- Internal state:
  - `cnt[DIV_W-1:0]`: cycles elapsed in the current half-period.
  - `divided` register.
  - `tick` register, only when `CLKDIV_TICK_EN` is defined.
- Effective limit `lim` = `division - 1`; when `division == 0`, `lim` = 0, so 0 behaves exactly like 1.
- Each rising `clk` edge, reset released:
  - If `cnt >= lim`: `cnt <= 0` and `divided <= ~divided` (toggle event).
  - Otherwise: `cnt <= cnt + 1` and `divided` holds.
- Resulting waveform:
  - `division = 1`: toggles every cycle (f_clk/2).
  - `division = N`: high for N cycles, low for N cycles (f_clk/(2N)).
- Run-time change of `division`:
  - Takes effect on the next edge; no pipeline register on the input.
  - Comparison is `>=`, so if `cnt` already meets or exceeds the new `lim`, the toggle happens on the next edge. This covers shrinking `division` below the current count; there is no wrap through 2^DIV_W.
  - `cnt` is not cleared on a change.
- Counter arithmetic is unsigned `DIV_W` bits. `cnt` never exceeds `lim`, except transiently after `division` shrinks, as described above.

## Timing
- Reset values: `divided = 0`, `cnt = 0`, `tick = 0`.
  - Applied immediately on `rst` assertion, independent of `clk`.
  - Held while `rst` is high, including across rising edges.
- First rising edge after `rst` falls, with `division = 1`: `divided` becomes 1.
- Toggle-to-output latency is zero: `divided` changes on the same edge at which `cnt >= lim` is evaluated.
- Reset asserted mid-count clears all state. Counting restarts from `cnt = 0`, `divided = 0`.
- `rst` release is assumed synchronised to `clk` by the reset block upstream. The divider adds no synchroniser of its own.

## Configuration
- `CLKDIV_TICK_EN` defined:
  - Adds output `tick`.
  - `tick <= 1` on every edge where a toggle event occurs; otherwise `tick <= 0`.
  - `tick` is therefore high for exactly one `clk` cycle after each edge of `divided`.
  - Reset value is 0.
- `CLKDIV_TICK_EN` undefined:
  - The `tick` port and its flop are absent.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Hold `rst = 1` across several edges: `divided = 0` throughout.
  - Assert `rst` between edges: `divided` goes to 0 immediately.
- `division = 1`, release `rst`: sampled at each falling edge after successive rising edges, `divided` reads 1, 0, 1, 0.
- Retune from 1 to 2 on a cycle where `divided = 1`: the next five half-cycle samples read 1, 0, 0, 1, 1.
- `division = 0` behaves identically to `division = 1`: toggle every cycle.
- `division = 5` for 40 cycles:
  - Period is 10 cycles; high and low each last exactly 5 cycles.
- Shrink mid-count: with `division = 8` and `cnt = 6`, write `division = 3`. `divided` toggles on the next edge, then follows a 3-cycle half-period.
- With `CLKDIV_TICK_EN` and `division = 3`:
  - `tick` pulses for 1 cycle every 3 cycles.
  - Each pulse is in the cycle following a `divided` transition.
  - `tick = 0` during and right after reset.
